// File: rtl/ethernet_header_builder.sv
`default_nettype none
// ============================================================================
// Module   : ethernet_header_builder
// Purpose  : Builds the transmit frame from a header (dst MAC, src MAC,
//            EtherType) and a 64-bit AXI-Stream payload: 14 header bytes,
//            then the payload realigned by 6 lanes, no FCS. Frame byte i is
//            carried on lane i%8.
// Ports    : clk, clear (sync active-high reset)
//            hdr_valid/hdr_ready, dst_mac, src_mac, eth_type : header input
//            s_tdata/s_tkeep/s_tlast/s_tvalid/s_tready       : payload input
//            m_tdata/m_tkeep/m_tlast/m_tvalid/m_tready       : framed output
//            busy : high whenever the FSM is not in IDLE
// Config   : `define ETH_TX_PAD_EN to zero-pad short frames to
//            MIN_FRAME_BYTES (adds an output byte counter and a PAD state).
// Revision : 1.0 - initial release
// ============================================================================
module ethernet_header_builder #(
  parameter int DATA_W          = 64,
  parameter int MIN_FRAME_BYTES = 60
) (
  input  logic                clk,
  input  logic                clear,
  input  logic                hdr_valid,
  output logic                hdr_ready,
  input  logic [47:0]         dst_mac,
  input  logic [47:0]         src_mac,
  input  logic [15:0]         eth_type,
  input  logic [DATA_W-1:0]   s_tdata,
  input  logic [DATA_W/8-1:0] s_tkeep,
  input  logic                s_tlast,
  input  logic                s_tvalid,
  output logic                s_tready,
  output logic [DATA_W-1:0]   m_tdata,
  output logic [DATA_W/8-1:0] m_tkeep,
  output logic                m_tlast,
  output logic                m_tvalid,
  input  logic                m_tready,
  output logic                busy
);

  // The lane arithmetic below is written for a 64-bit bus only.
  if (DATA_W != 64) begin : g_bad_data_w
    $error("ethernet_header_builder: only DATA_W=64 is supported");
  end
  if (MIN_FRAME_BYTES < 16 || MIN_FRAME_BYTES > 64) begin : g_bad_min_frame
    $error("ethernet_header_builder: MIN_FRAME_BYTES must be 16..64");
  end

`ifdef ETH_TX_PAD_EN
  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_HDR0 = 3'd1, S_HDR1 = 3'd2,
    S_BODY = 3'd3, S_TAIL = 3'd4, S_PAD  = 3'd5
  } state_t;
  localparam logic [7:0] c_min = 8'(MIN_FRAME_BYTES);
`else
  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_HDR0 = 3'd1, S_HDR1 = 3'd2,
    S_BODY = 3'd3, S_TAIL = 3'd4
  } state_t;
`endif

  state_t        state_q, state_d;
  logic [31:0]   src_lo_q, src_lo_d;   // src_mac bytes 2-5, sent in beat 1
  logic [15:0]   type_q, type_d;
  logic [47:0]   hold_q, hold_d;       // payload lanes 2-7 of previous beat
  logic [3:0]    n_q, n_d;             // byte count of the last input beat
  logic [63:0]   m_tdata_q, tdata_d;
  logic [7:0]    m_tkeep_q, tkeep_d;
  logic          m_tlast_q, tlast_d;
  logic          m_tvalid_q, tvalid_d;
  logic          busy_q, busy_d;

  logic          w_adv;
  logic          w_hdr_hs;
  logic          w_s_hs;
  logic [63:0]   w_kmask;
  logic [63:0]   w_pdata;
  logic [3:0]    w_n;
  logic [63:0]   w_beat;
  logic          w_fin;
  logic [63:0]   w_fin_data;
  logic [3:0]    w_fin_bytes;

  function automatic logic [7:0] f_keep(input logic [3:0] nbytes);
    logic [8:0] m;
    m = (9'd1 << nbytes) - 9'd1;
    return m[7:0];
  endfunction

  assign w_adv     = !m_tvalid_q || m_tready;
  assign hdr_ready = (state_q == S_IDLE) && w_adv;
  assign s_tready  = ((state_q == S_HDR1) || (state_q == S_BODY)) && w_adv;
  assign w_hdr_hs  = hdr_valid && hdr_ready;
  assign w_s_hs    = s_tvalid && s_tready;

  // Zero the disabled payload lanes so they never leak onto the output.
  for (genvar i = 0; i < 8; i++) begin : g_keep_mask
    assign w_kmask[8*i +: 8] = {8{s_tkeep[i]}};
  end
  assign w_pdata = s_tdata & w_kmask;

  always_comb begin
    w_n = '0;
    for (int i = 0; i < 8; i++) begin
      w_n = w_n + {3'b000, s_tkeep[i]};
    end
  end

  // Beat 1 carries the rest of the header; later beats splice the held
  // lanes 2-7 with the new lanes 0-1.
  assign w_beat = (state_q == S_HDR1)
                ? {w_pdata[15:0], type_q[7:0], type_q[15:8],
                   src_lo_q[7:0], src_lo_q[15:8], src_lo_q[23:16], src_lo_q[31:24]}
                : {w_pdata[15:0], hold_q};

`ifdef ETH_TX_PAD_EN
  logic [6:0] cnt_q, cnt_d;            // frame bytes already loaded, saturating
  logic [7:0] w_rem;                   // bytes still needed to reach the minimum
  logic [7:0] w_total;
  logic       w_loaded;

  assign w_rem    = c_min - {1'b0, cnt_q};
  assign w_loaded = (((state_q == S_HDR1) || (state_q == S_BODY)) && w_s_hs) ||
                    (((state_q == S_TAIL) || (state_q == S_PAD)) && w_adv);

  always_comb begin
    cnt_d = cnt_q;
    if (w_hdr_hs) begin
      cnt_d = 7'd8;
    end else if (w_loaded) begin
      cnt_d = (cnt_q >= 7'd56) ? 7'd64 : cnt_q + 7'd8;
    end
  end
`endif

  always_comb begin
    state_d     = state_q;
    src_lo_d    = src_lo_q;
    type_d      = type_q;
    hold_d      = hold_q;
    n_d         = n_q;
    tdata_d     = m_tdata_q;
    tkeep_d     = m_tkeep_q;
    tlast_d     = m_tlast_q;
    tvalid_d    = m_tvalid_q && !m_tready;
    w_fin       = 1'b0;
    w_fin_data  = '0;
    w_fin_bytes = '0;
`ifdef ETH_TX_PAD_EN
    w_total     = '0;
`endif

    case (state_q)
      S_IDLE: begin
        if (w_hdr_hs) begin
          src_lo_d = src_mac[31:0];
          type_d   = eth_type;
          // Beat 0 goes straight to the output register for latency 1.
          tdata_d  = {src_mac[39:32], src_mac[47:40],
                      dst_mac[7:0], dst_mac[15:8], dst_mac[23:16],
                      dst_mac[31:24], dst_mac[39:32], dst_mac[47:40]};
          tkeep_d  = 8'hFF;
          tlast_d  = 1'b0;
          tvalid_d = 1'b1;
          state_d  = S_HDR0;
        end
      end
      S_HDR0: begin
        if (w_adv) begin
          state_d = S_HDR1;
        end
      end
      S_HDR1, S_BODY: begin
        if (w_s_hs) begin
          hold_d = w_pdata[63:16];
          if (s_tlast && (w_n <= 4'd2)) begin
            w_fin       = 1'b1;
            w_fin_data  = w_beat;
            w_fin_bytes = 4'd6 + w_n;
          end else begin
            tdata_d  = w_beat;
            tkeep_d  = 8'hFF;
            tlast_d  = 1'b0;
            tvalid_d = 1'b1;
            n_d      = w_n;
            state_d  = s_tlast ? S_TAIL : S_BODY;
          end
        end
      end
      S_TAIL: begin
        if (w_adv) begin
          w_fin       = 1'b1;
          w_fin_data  = {16'h0000, hold_q};
          w_fin_bytes = n_q - 4'd2;
        end
      end
`ifdef ETH_TX_PAD_EN
      S_PAD: begin
        if (w_adv) begin
          tdata_d  = '0;
          tvalid_d = 1'b1;
          if (w_rem <= 8'd8) begin
            tkeep_d = f_keep(w_rem[3:0]);
            tlast_d = 1'b1;
            state_d = S_IDLE;
          end else begin
            tkeep_d = 8'hFF;
            tlast_d = 1'b0;
          end
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase

    // Final payload beat: normally ends the frame; with padding enabled a
    // short frame keeps going with zero bytes up to the minimum length.
    if (w_fin) begin
      tdata_d  = w_fin_data;
      tvalid_d = 1'b1;
`ifdef ETH_TX_PAD_EN
      w_total = {1'b0, cnt_q} + {4'b0000, w_fin_bytes};
      if (w_total >= c_min) begin
        tkeep_d = f_keep(w_fin_bytes);
        tlast_d = 1'b1;
        state_d = S_IDLE;
      end else if (w_rem <= 8'd8) begin
        tkeep_d = f_keep(w_rem[3:0]);
        tlast_d = 1'b1;
        state_d = S_IDLE;
      end else begin
        tkeep_d = 8'hFF;
        tlast_d = 1'b0;
        state_d = S_PAD;
      end
`else
      tkeep_d = f_keep(w_fin_bytes);
      tlast_d = 1'b1;
      state_d = S_IDLE;
`endif
    end

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      state_q    <= S_IDLE;
      src_lo_q   <= '0;
      type_q     <= '0;
      hold_q     <= '0;
      n_q        <= '0;
      m_tdata_q  <= '0;
      m_tkeep_q  <= '0;
      m_tlast_q  <= 1'b0;
      m_tvalid_q <= 1'b0;
      busy_q     <= 1'b0;
`ifdef ETH_TX_PAD_EN
      cnt_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      src_lo_q   <= src_lo_d;
      type_q     <= type_d;
      hold_q     <= hold_d;
      n_q        <= n_d;
      m_tdata_q  <= tdata_d;
      m_tkeep_q  <= tkeep_d;
      m_tlast_q  <= tlast_d;
      m_tvalid_q <= tvalid_d;
      busy_q     <= busy_d;
`ifdef ETH_TX_PAD_EN
      cnt_q      <= cnt_d;
`endif
    end
  end

  assign m_tdata  = m_tdata_q;
  assign m_tkeep  = m_tkeep_q;
  assign m_tlast  = m_tlast_q;
  assign m_tvalid = m_tvalid_q;
  assign busy     = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_ethernet_header_builder.sv
`default_nettype none
// ============================================================================
// Module   : tb_ethernet_header_builder
// Purpose  : Scoreboard bench for ethernet_header_builder. Each frame is
//            turned into its expected output beats by a byte-level model
//            (header bytes + payload bytes, optionally zero-padded, cut into
//            8-byte beats); a monitor pops and compares every output beat.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ethernet_header_builder;

  typedef logic [7:0] bq_t[$];
  typedef struct packed {
    logic [63:0] d;
    logic [7:0]  k;
    logic        l;
  } beat_t;

  localparam int TMO = 300;

  logic        clk = 1'b0;
  logic        clear;
  logic        hdr_valid;
  logic        hdr_ready;
  logic [47:0] dst_mac;
  logic [47:0] src_mac;
  logic [15:0] eth_type;
  logic [63:0] s_tdata;
  logic [7:0]  s_tkeep;
  logic        s_tlast;
  logic        s_tvalid;
  logic        s_tready;
  logic [63:0] m_tdata;
  logic [7:0]  m_tkeep;
  logic        m_tlast;
  logic        m_tvalid;
  logic        m_tready;
  logic        busy;

  int    total = 0;
  int    bad   = 0;
  int    rmode = 0;   // 0: always ready, 1: toggle, 2: random
  bit    mon_en = 1'b1;
  beat_t exp_q[$];

  ethernet_header_builder dut (
    .clk      (clk),
    .clear    (clear),
    .hdr_valid(hdr_valid),
    .hdr_ready(hdr_ready),
    .dst_mac  (dst_mac),
    .src_mac  (src_mac),
    .eth_type (eth_type),
    .s_tdata  (s_tdata),
    .s_tkeep  (s_tkeep),
    .s_tlast  (s_tlast),
    .s_tvalid (s_tvalid),
    .s_tready (s_tready),
    .m_tdata  (m_tdata),
    .m_tkeep  (m_tkeep),
    .m_tlast  (m_tlast),
    .m_tvalid (m_tvalid),
    .m_tready (m_tready),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: the frame as a flat byte list, then cut into beats.
  task automatic model_push(input logic [47:0] d, input logic [47:0] s,
                            input logic [15:0] t, input bq_t pl);
    bq_t   fb;
    beat_t bt;
    fb = {};
    for (int i = 5; i >= 0; i--) fb.push_back(d[8*i +: 8]);
    for (int i = 5; i >= 0; i--) fb.push_back(s[8*i +: 8]);
    fb.push_back(t[15:8]);
    fb.push_back(t[7:0]);
    foreach (pl[i]) fb.push_back(pl[i]);
`ifdef ETH_TX_PAD_EN
    while (fb.size() < 60) fb.push_back(8'h00);
`endif
    for (int b = 0; b * 8 < fb.size(); b++) begin
      bt = '0;
      for (int l = 0; l < 8; l++) begin
        if (b * 8 + l < fb.size()) begin
          bt.d[8*l +: 8] = fb[b * 8 + l];
          bt.k[l]        = 1'b1;
        end
      end
      bt.l = ((b + 1) * 8 >= fb.size());
      exp_q.push_back(bt);
    end
  endtask

  // Monitor: scoreboard pop on every handshake, plus stall checks.
  logic        prev_stall = 1'b0;
  logic [63:0] prev_d;
  logic [7:0]  prev_k;
  logic        prev_l;
  always @(negedge clk) begin
    beat_t e;
    if (clear || !mon_en) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_valid", {63'b0, m_tvalid}, 64'd1);
        check("stall_data", m_tdata, prev_d);
        check("stall_keep", {56'b0, m_tkeep}, {56'b0, prev_k});
        check("stall_last", {63'b0, m_tlast}, {63'b0, prev_l});
      end
      if (m_tvalid && !m_tready) begin
        check("stall_s_tready", {63'b0, s_tready}, 64'd0);
        prev_stall = 1'b1;
        prev_d     = m_tdata;
        prev_k     = m_tkeep;
        prev_l     = m_tlast;
      end else begin
        prev_stall = 1'b0;
      end
      if (m_tvalid && m_tready) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_beat: got data %h keep %h with no beat expected", m_tdata, m_tkeep);
        end else begin
          e = exp_q.pop_front();
          check("beat_data", m_tdata, e.d);
          check("beat_keep", {56'b0, m_tkeep}, {56'b0, e.k});
          check("beat_last", {63'b0, m_tlast}, {63'b0, e.l});
        end
      end
    end
  end

  initial begin
    m_tready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rmode)
        0:       m_tready = 1'b1;
        1:       m_tready = ~m_tready;
        default: m_tready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  task automatic wait_hdr();
    int k;
    for (k = 0; k < TMO; k++) begin
      @(negedge clk);
      if (hdr_ready) break;
    end
    if (k == TMO) begin
      total++;
      bad++;
      $display("FAIL hdr_timeout: hdr_ready stayed 0 for %0d cycles, expected 1", TMO);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send_payload(input bq_t pl, input bit gaps, input bit with_last);
    int nb;
    int k;
    int g;
    nb = (pl.size() + 7) / 8;
    for (int b = 0; b < nb; b++) begin
      if (gaps) begin
        g = int'($urandom_range(0, 2));
        if (g > 0) begin
          s_tvalid = 1'b0;
          repeat (g) @(posedge clk);
          #1;
        end
      end
      s_tdata = '0;
      s_tkeep = '0;
      for (int l = 0; l < 8; l++) begin
        if (b * 8 + l < pl.size()) begin
          s_tdata[8*l +: 8] = pl[b * 8 + l];
          s_tkeep[l]        = 1'b1;
        end
      end
      s_tlast  = with_last && (b == nb - 1);
      s_tvalid = 1'b1;
      for (k = 0; k < TMO; k++) begin
        @(negedge clk);
        if (s_tready) break;
      end
      if (k == TMO) begin
        total++;
        bad++;
        $display("FAIL s_timeout: s_tready stayed 0 for %0d cycles, expected 1", TMO);
      end
      @(posedge clk);
      #1;
    end
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  task automatic send_frame(input logic [47:0] d, input logic [47:0] s, input logic [15:0] t,
                            input bq_t pl, input bit gaps, input bit lat);
    model_push(d, s, t, pl);
    dst_mac   = d;
    src_mac   = s;
    eth_type  = t;
    hdr_valid = 1'b1;
    wait_hdr();
    hdr_valid = 1'b0;
    if (lat) begin
      @(negedge clk);
      check("hdr_latency_valid", {63'b0, m_tvalid}, 64'd1);
      check("hdr_latency_busy", {63'b0, busy}, 64'd1);
      check("hdr_ready_busy", {63'b0, hdr_ready}, 64'd0);
    end
    send_payload(pl, gaps, 1'b1);
  endtask

  task automatic drain();
    int k;
    for (k = 0; k < TMO * 4; k++) begin
      @(negedge clk);
      if (exp_q.size() == 0) break;
    end
    if (k == TMO * 4) begin
      total++;
      bad++;
      $display("FAIL drain_timeout: %0d beats still expected, required 0", exp_q.size());
      exp_q.delete();
    end
    @(posedge clk);
    #1;
  endtask

  function automatic bq_t seq_bytes(input int n, input int base);
    bq_t q;
    q = {};
    for (int i = 0; i < n; i++) q.push_back(8'(base + i));
    return q;
  endfunction

  function automatic bq_t rnd_bytes(input int n);
    bq_t q;
    q = {};
    for (int i = 0; i < n; i++) q.push_back(8'($urandom_range(0, 255)));
    return q;
  endfunction

  localparam logic [47:0] DST = 48'h001122334455;
  localparam logic [47:0] SRC = 48'h66778899AABB;
  localparam logic [15:0] TYP = 16'h0800;

  initial begin
    bq_t pl;
    clear     = 1'b1;
    hdr_valid = 1'b0;
    dst_mac   = '0;
    src_mac   = '0;
    eth_type  = '0;
    s_tdata   = '0;
    s_tkeep   = '0;
    s_tlast   = 1'b0;
    s_tvalid  = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_m_tvalid", {63'b0, m_tvalid}, 64'd0);
    check("rst_m_tdata", m_tdata, 64'd0);
    check("rst_m_tkeep", {56'b0, m_tkeep}, 64'd0);
    check("rst_m_tlast", {63'b0, m_tlast}, 64'd0);
    check("rst_busy", {63'b0, busy}, 64'd0);
    check("rst_hdr_ready", {63'b0, hdr_ready}, 64'd1);
    @(posedge clk);
    #1;
    clear = 1'b0;

    // Full 8-byte payload: header beats, then a 6-byte tail beat.
    send_frame(DST, SRC, TYP, seq_bytes(8, 0), 1'b0, 1'b1);
    drain();

    // Two-byte payload: frame ends on beat 1, no tail.
    send_frame(DST, SRC, TYP, seq_bytes(2, 0), 1'b0, 1'b0);
    drain();

    // Four beats, last carries 4 bytes.
    send_frame(DST, SRC, TYP, seq_bytes(28, 8'h40), 1'b0, 1'b0);
    drain();

    // Output stalled every other cycle over a 3-beat payload.
    rmode = 1;
    send_frame(48'hA1A2A3A4A5A6, 48'hB1B2B3B4B5B6, 16'h86DD, seq_bytes(24, 8'h80), 1'b0, 1'b0);
    drain();
    rmode = 0;

    // Abort in BODY with clear, then a clean frame.
    mon_en    = 1'b0;
    dst_mac   = DST;
    src_mac   = SRC;
    eth_type  = TYP;
    hdr_valid = 1'b1;
    wait_hdr();
    hdr_valid = 1'b0;
    send_payload(seq_bytes(16, 8'hC0), 1'b0, 1'b0);
    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
    @(negedge clk);
    check("abort_m_tvalid", {63'b0, m_tvalid}, 64'd0);
    check("abort_busy", {63'b0, busy}, 64'd0);
    check("abort_hdr_ready", {63'b0, hdr_ready}, 64'd1);
    exp_q.delete();
    mon_en = 1'b1;
    @(posedge clk);
    #1;
    send_frame(DST, SRC, TYP, seq_bytes(8, 0), 1'b0, 1'b0);
    drain();

    // Short 8-byte payload (padded to 60 bytes when padding is built in).
    send_frame(DST, SRC, TYP, rnd_bytes(8), 1'b0, 1'b0);
    drain();

    // Randomized frames: random header, length, gaps and back-pressure,
    // issued back to back.
    for (int f = 0; f < 40; f++) begin
      rmode = int'($urandom_range(0, 2));
      pl = rnd_bytes(int'($urandom_range(1, 56)));
      send_frame({$urandom, $urandom}, {$urandom, $urandom}, 16'($urandom),
                 pl, 1'($urandom_range(0, 1)), 1'b0);
    end
    rmode = 0;
    drain();
    repeat (4) @(negedge clk);
    check("final_queue_empty", 64'(exp_q.size()), 64'd0);
    check("final_busy", {63'b0, busy}, 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
